// File: rtl/sha256_round_engine_if.sv
// Stream, K-ROM and digest signals of the SHA-256 round engine.
// The master side is the environment (word-stream padder, K ROM, digest register).
interface sha256_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_first;
    logic [6:0]   k_idx;
    logic [31:0]  k_val;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    modport master (
        output in_valid, in_data, in_first, k_val,
        input  in_ready, k_idx, digest, digest_valid, busy
    );

    modport slave (
        input  in_valid, in_data, in_first, k_val,
        output in_ready, k_idx, digest, digest_valid, busy
    );
endinterface

// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: one round per cycle, on-the-fly message schedule,
// chaining value held internally and presented with a one-cycle valid pulse.
module sha256_round_engine #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_round_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

    localparam logic [6:0]  LAST_LOAD  = 7'd15;
    localparam logic [6:0]  LAST_ROUND = 7'(NUM_ROUNDS - 1);
    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state, state_d;
    logic [6:0]  t, t_d;
    logic        do_round, load_base, finish;
    logic        dv;
    logic [31:0] w     [16];  // w[15] = W(t-1) ... w[0] = W(t-16)
    logic [31:0] wk    [8];   // working a..h
    logic [31:0] base  [8];   // chaining value the current block started from
    logic [31:0] hv    [8];
    logic [31:0] chain [8];
    logic [31:0] cur   [8];
    logic [31:0] nxt   [8];
    logic [31:0] w_exp, w_cur, t1, t2, sig0, sig1, ch, maj;

    assign bus.in_ready     = (state == IDLE) || (state == LOAD);
    assign bus.busy         = (state != IDLE);
    assign bus.k_idx        = t;
    assign bus.digest_valid = dv;
    assign bus.digest       = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            // NOTE: non-blocking everywhere in clocked blocks so every register
            // samples the pre-edge values and process order cannot matter.
            state <= state_d;
            t     <= t_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state;
        t_d       = t;
        do_round  = 1'b0;
        load_base = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                load_base = 1'b1;
                do_round  = 1'b1;
                t_d       = 7'd1;
                state_d   = LOAD;
            end
            LOAD: if (bus.in_valid) begin
                do_round = 1'b1;
                t_d      = t + 7'd1;
                if (t == LAST_LOAD) state_d = ROUND;
            end
            ROUND: begin
                do_round = 1'b1;
                t_d      = t + 7'd1;
                if (t == LAST_ROUND) state_d = FINAL;
            end
            FINAL: begin
                finish  = 1'b1;
                t_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            chain[i] = bus.in_first ? H_INIT[i] : hv[i];
            cur[i]   = (state == IDLE) ? chain[i] : wk[i];
        end
        w_exp = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
        w_cur = (state == ROUND) ? w_exp : bus.in_data;

        sig1 = ror(cur[4], 6) ^ ror(cur[4], 11) ^ ror(cur[4], 25);
        ch   = (cur[4] & cur[5]) ^ (~cur[4] & cur[6]);
        t1   = cur[7] + sig1 + ch + bus.k_val + w_cur;
        sig0 = ror(cur[0], 2) ^ ror(cur[0], 13) ^ ror(cur[0], 22);
        maj  = (cur[0] & cur[1]) ^ (cur[0] & cur[2]) ^ (cur[1] & cur[2]);
        t2   = sig0 + maj;

        nxt[0] = t1 + t2;
        nxt[1] = cur[0];
        nxt[2] = cur[1];
        nxt[3] = cur[2];
        nxt[4] = cur[3] + t1;
        nxt[5] = cur[4];
        nxt[6] = cur[5];
        nxt[7] = cur[6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: schedule and working arrays are reset as well, so an aborted
            // block leaves nothing behind that a later block could observe.
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                wk[i]   <= '0;
                base[i] <= '0;
                hv[i]   <= H_INIT[i];
            end
            dv <= 1'b0;
        end else begin
            if (do_round) begin
                for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                w[15] <= w_cur;
                for (int i = 0; i < 8; i++) wk[i] <= nxt[i];
            end
            if (load_base) begin
                for (int i = 0; i < 8; i++) base[i] <= chain[i];
            end
            if (finish) begin
                for (int i = 0; i < 8; i++) hv[i] <= base[i] + wk[i];
            end
            dv <= finish;
        end
    end
endmodule
